// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state and bus size encodings for the memory bus arbiter
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DBUSY = 2'd1, IBUSY = 2'd2} state_t;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: external memory port (MREQ/WRITE/SIZE/ACK_n style)
interface mem_bus_arbiter_if #(parameter int BIT_WIDTH = 32);
  logic                 m_req;
  logic                 m_write;
  logic [1:0]           m_size;
  logic [BIT_WIDTH-1:0] m_addr;
  logic [BIT_WIDTH-1:0] m_wdata;
  logic                 m_wdata_oe;
  logic [BIT_WIDTH-1:0] m_rdata;
  logic                 m_ack_n;
  modport master (output m_req, m_write, m_size, m_addr, m_wdata, m_wdata_oe, input m_rdata, m_ack_n);
  modport slave (input m_req, m_write, m_size, m_addr, m_wdata, m_wdata_oe, output m_rdata, m_ack_n);
endinterface

// File: rtl/mem_bus_watchdog.sv
// mem_bus_watchdog: busy-cycle counter flagging the last allowed cycle of a transaction
module mem_bus_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT);
  logic [W-1:0] tmo_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) tmo_cnt <= '0;
    else if (clr) tmo_cnt <= '0;
    else if (en) tmo_cnt <= tmo_cnt + W'(1);
  assign expire = en && tmo_cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between fetch and data requesters
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic [BIT_WIDTH-1:0] i_addr,
  output logic [BIT_WIDTH-1:0] i_rdata,
  output logic                 i_ack_n,
  input  logic                 d_req,
  input  logic                 d_write,
  input  logic [1:0]           d_size,
  input  logic [BIT_WIDTH-1:0] d_addr,
  input  logic [BIT_WIDTH-1:0] d_wdata,
  output logic [BIT_WIDTH-1:0] d_rdata,
  output logic                 d_ack_n,
  mem_bus_arbiter_if.master    m,
  output logic                 bus_err
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  state_t               state;
  logic [SW-1:0]        starve_cnt;
  logic                 busy, expire, done, grant_i, grant_d;
  logic [BIT_WIDTH-1:0] rvalue;
  assign busy    = state != IDLE;
  assign done    = busy && (!m.m_ack_n || expire);
  assign grant_i = i_req && (!d_req || starve_cnt == SW'(STARVE_MAX));
  assign grant_d = d_req && !grant_i;
  // stores and timeouts return zero rather than whatever floats on the bus
  assign rvalue  = (!m.m_ack_n && !m.m_write) ? m.m_rdata : '0;
  mem_bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!busy || done),
    .en     (busy),
    .expire (expire)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      m.m_req      <= 1'b0;
      m.m_write    <= 1'b0;
      m.m_size     <= SZ_WORD;
      m.m_addr     <= '0;
      m.m_wdata    <= '0;
      m.m_wdata_oe <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_ack_n      <= 1'b1;
      d_ack_n      <= 1'b1;
      bus_err      <= 1'b0;
    end else begin
      i_ack_n <= 1'b1;
      d_ack_n <= 1'b1;
      bus_err <= 1'b0;
      if (!busy) begin
        if (grant_i) begin
          state        <= IBUSY;
          starve_cnt   <= '0;
          m.m_req      <= 1'b1;
          m.m_write    <= 1'b0;
          m.m_size     <= SZ_WORD;
          m.m_addr     <= i_addr;
          m.m_wdata    <= '0;
          m.m_wdata_oe <= 1'b0;
        end else if (grant_d) begin
          state        <= DBUSY;
          starve_cnt   <= !i_req ? '0 : starve_cnt == SW'(STARVE_MAX) ? starve_cnt : starve_cnt + SW'(1);
          m.m_req      <= 1'b1;
          m.m_write    <= d_write;
          m.m_size     <= d_size;
          m.m_addr     <= d_addr;
          m.m_wdata    <= d_wdata;
          m.m_wdata_oe <= d_write;
        end
      end else if (done) begin
        state        <= IDLE;
        m.m_req      <= 1'b0;
        m.m_wdata_oe <= 1'b0;
        bus_err      <= m.m_ack_n;
        if (state == IBUSY) begin
          i_ack_n <= 1'b0;
          i_rdata <= rvalue;
        end else begin
          d_ack_n <= 1'b0;
          d_rdata <= rvalue;
        end
      end
    end
endmodule
